// File: rtl/base_scatter_if.sv
// Handshake bundle for base_scatter: one keyed upstream item in, per-way valid/ready out.
interface base_scatter_if #(
  parameter int ways      = 2,
  parameter int kw        = 1,
  parameter int dw        = 1,
  parameter int aux_width = 1
);

  logic                 i_v;
  logic                 i_r;
  logic [ways-1:0]      i_m;
  logic [kw-1:0]        i_k;
  logic [dw-1:0]        i_d;
  logic [aux_width-1:0] i_aux;

  logic [ways-1:0]      o_v;
  logic [ways-1:0]      o_r;
  logic [kw-1:0]        o_k;
  logic [dw-1:0]        o_d;
  logic [aux_width-1:0] o_aux;

  // Upstream producer plus downstream consumers, i.e. everything around the scatter.
  modport master (
    output i_v, i_m, i_k, i_d, i_aux, o_r,
    input  i_r, o_v, o_k, o_d, o_aux
  );

  modport slave (
    input  i_v, i_m, i_k, i_d, i_aux, o_r,
    output i_r, o_v, o_k, o_d, o_aux
  );

endinterface

// File: rtl/base_scatter.sv
// Keyed item scatter: one holding register delivers each item to every way in its mask.
// Optional saturating zero-mask drop counter enabled by BASE_SCATTER_DROP_CNT_EN.
module base_scatter #(
  parameter int ways      = 2,
  parameter int kw        = 1,
  parameter int dw        = 1,
  parameter int aux_width = 1
`ifdef BASE_SCATTER_DROP_CNT_EN
  , parameter int cw      = 16
`endif
) (
  input  logic          clk,
  input  logic          reset,
  base_scatter_if.slave bus
`ifdef BASE_SCATTER_DROP_CNT_EN
  , output logic [cw-1:0] o_drop_cnt
`endif
);

  logic [ways-1:0]      pm;
  logic [ways-1:0]      acc;
  logic [ways-1:0]      rem;
  logic                 done;
  logic                 take;
  logic [kw-1:0]        k_q;
  logic [dw-1:0]        d_q;
  logic [aux_width-1:0] aux_q;

  // done also covers the cycle in which the last pending ways accept, so a new
  // item can be taken with no bubble.
  always_comb begin
    acc  = pm & bus.o_r;
    rem  = pm & ~acc;
    done = (rem == '0);
    take = done & bus.i_v;
  end

  assign bus.i_r   = done;
  assign bus.o_v   = pm;
  assign bus.o_k   = k_q;
  assign bus.o_d   = d_q;
  assign bus.o_aux = aux_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pm    <= '0;
      k_q   <= '0;
      d_q   <= '0;
      aux_q <= '0;
    end else begin
      pm <= take ? bus.i_m : rem;
      // A zero-mask item is consumed without disturbing the (invisible) payload.
      if (take && (bus.i_m != '0)) begin
        k_q   <= bus.i_k;
        d_q   <= bus.i_d;
        aux_q <= bus.i_aux;
      end
    end
  end

`ifdef BASE_SCATTER_DROP_CNT_EN
  logic [cw-1:0] drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (take && (bus.i_m == '0) && (drop_q != '1)) begin
      drop_q <= drop_q + cw'(1);
    end
  end

  assign o_drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_base_scatter.sv
// Scoreboard bench for base_scatter: a 4-way and a 1-way instance driven by directed vectors.
module tb_base_scatter;

  typedef struct packed {
    logic [7:0] k;
    logic [7:0] d;
    logic [3:0] aux;
  } item_t;

  logic clk;
  logic reset;
  int   checks;
  int   passes;

  item_t exp4 [4][$];
  item_t exp1 [$];

  base_scatter_if #(.ways(4), .kw(8), .dw(8), .aux_width(4)) bus4 ();
  base_scatter_if #(.ways(1), .kw(8), .dw(8), .aux_width(4)) bus1 ();

`ifdef BASE_SCATTER_DROP_CNT_EN
  logic [1:0]  drop_cnt4;
  logic [15:0] drop_cnt1;
`endif

  base_scatter #(
    .ways(4), .kw(8), .dw(8), .aux_width(4)
`ifdef BASE_SCATTER_DROP_CNT_EN
    , .cw(2)
`endif
  ) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
`ifdef BASE_SCATTER_DROP_CNT_EN
    , .o_drop_cnt(drop_cnt4)
`endif
  );

  base_scatter #(
    .ways(1), .kw(8), .dw(8), .aux_width(4)
`ifdef BASE_SCATTER_DROP_CNT_EN
    , .cw(16)
`endif
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
`ifdef BASE_SCATTER_DROP_CNT_EN
    , .o_drop_cnt(drop_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic item_t mkItem(input logic [7:0] k);
    mkItem.k   = k;
    mkItem.d   = ~k;
    mkItem.aux = k[3:0] ^ 4'hA;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
  endtask

  // Inputs change 1 time unit after the rising edge; xfer says a transfer is expected.
  task automatic applyStimulus(input logic v, input logic [3:0] m, input logic [7:0] k,
                               input logic [3:0] r, input bit xfer);
    item_t it;
    @(posedge clk);
    #1;
    it          = mkItem(k);
    bus4.i_v    = v;
    bus4.i_m    = m;
    bus4.i_k    = it.k;
    bus4.i_d    = it.d;
    bus4.i_aux  = it.aux;
    bus4.o_r    = r;
    if (xfer) begin
      for (int w = 0; w < 4; w++) if (m[w]) exp4[w].push_back(it);
    end
  endtask

  task automatic checkCycle(input string name, input logic [3:0] ov, input logic ir,
                            input logic [7:0] k);
    @(negedge clk);
    checkOutput({name, "_o_v"}, 32'(bus4.o_v), 32'(ov));
    checkOutput({name, "_i_r"}, 32'(bus4.i_r), 32'(ir));
    if (ov != 4'b0000) checkOutput({name, "_o_k"}, 32'(bus4.o_k), 32'(k));
  endtask

  task automatic applyStimulusOne(input logic v, input logic m, input logic [7:0] k,
                                  input logic r, input bit xfer);
    item_t it;
    @(posedge clk);
    #1;
    it         = mkItem(k);
    bus1.i_v   = v;
    bus1.i_m   = m;
    bus1.i_k   = it.k;
    bus1.i_d   = it.d;
    bus1.i_aux = it.aux;
    bus1.o_r   = r;
    if (xfer && m) exp1.push_back(it);
  endtask

  task automatic checkCycleOne(input string name, input logic ov, input logic ir,
                               input logic [7:0] k);
    @(negedge clk);
    checkOutput({name, "_o_v"}, 32'(bus1.o_v), 32'(ov));
    checkOutput({name, "_i_r"}, 32'(bus1.i_r), 32'(ir));
    if (ov) checkOutput({name, "_o_k"}, 32'(bus1.o_k), 32'(k));
  endtask

  // Monitor: pops the expected item whenever a way accepts, and checks that a
  // presented but unaccepted valid is still there on the next cycle.
  initial begin : monitor
    item_t      want;
    item_t      got;
    logic [3:0] prev4;
    logic       prev1;
    prev4 = '0;
    prev1 = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev4 = '0;
        prev1 = 1'b0;
      end else begin
        for (int w = 0; w < 4; w++) begin
          if (prev4[w]) checkOutput($sformatf("hold_w%0d", w), 32'(bus4.o_v[w]), 32'd1);
          if (bus4.o_v[w] && bus4.o_r[w]) begin
            checkOutput($sformatf("expected_w%0d", w), 32'(exp4[w].size() != 0), 32'd1);
            if (exp4[w].size() != 0) begin
              want = exp4[w].pop_front();
              got  = {bus4.o_k, bus4.o_d, bus4.o_aux};
              checkOutput($sformatf("item_w%0d", w), 32'(got), 32'(want));
            end
          end
        end
        prev4 = bus4.o_v & ~bus4.o_r;
        if (prev1) checkOutput("hold_one", 32'(bus1.o_v), 32'd1);
        if (bus1.o_v[0] && bus1.o_r[0]) begin
          checkOutput("expected_one", 32'(exp1.size() != 0), 32'd1);
          if (exp1.size() != 0) begin
            want = exp1.pop_front();
            got  = {bus1.o_k, bus1.o_d, bus1.o_aux};
            checkOutput("item_one", 32'(got), 32'(want));
          end
        end
        prev1 = bus1.o_v[0] & ~bus1.o_r[0];
      end
    end
  end

  initial begin : stimulus
    checks = 0;
    passes = 0;
    reset  = 1'b0;
    bus4.i_v = 1'b0; bus4.i_m = '0; bus4.i_k = '0; bus4.i_d = '0; bus4.i_aux = '0; bus4.o_r = '0;
    bus1.i_v = 1'b0; bus1.i_m = '0; bus1.i_k = '0; bus1.i_d = '0; bus1.i_aux = '0; bus1.o_r = '0;

    #12;
    checkOutput("rst_o_v", 32'(bus4.o_v), 32'd0);
    checkOutput("rst_i_r", 32'(bus4.i_r), 32'd1);
    checkOutput("rst_o_k", 32'(bus4.o_k), 32'd0);
    checkOutput("rst_o_d", 32'(bus4.o_d), 32'd0);
    checkOutput("rst_o_aux", 32'(bus4.o_aux), 32'd0);
    checkOutput("rst_one_o_v", 32'(bus1.o_v), 32'd0);
`ifdef BASE_SCATTER_DROP_CNT_EN
    checkOutput("rst_drop_cnt", 32'(drop_cnt4), 32'd0);
`endif
    #10 reset = 1'b1;

    // Unicast streaming, one way per cycle, all ready.
    applyStimulus(1'b1, 4'b0001, 8'hA0, 4'hF, 1'b1); checkCycle("uni0", 4'b0000, 1'b1, 8'h00);
    applyStimulus(1'b1, 4'b0010, 8'hA1, 4'hF, 1'b1); checkCycle("uni1", 4'b0001, 1'b1, 8'hA0);
    applyStimulus(1'b1, 4'b0100, 8'hA2, 4'hF, 1'b1); checkCycle("uni2", 4'b0010, 1'b1, 8'hA1);
    applyStimulus(1'b1, 4'b1000, 8'hA3, 4'hF, 1'b1); checkCycle("uni3", 4'b0100, 1'b1, 8'hA2);
    applyStimulus(1'b0, 4'b0000, 8'h00, 4'hF, 1'b0); checkCycle("uni4", 4'b1000, 1'b1, 8'hA3);
    applyStimulus(1'b0, 4'b0000, 8'h00, 4'hF, 1'b0); checkCycle("uni5", 4'b0000, 1'b1, 8'h00);

    // Multicast with staggered ready, then a back-to-back item on the final accept.
    applyStimulus(1'b1, 4'b1111, 8'h5A, 4'b0000, 1'b1); checkCycle("mc0", 4'b0000, 1'b1, 8'h00);
    applyStimulus(1'b0, 4'b0000, 8'h00, 4'b0100, 1'b0); checkCycle("mc1", 4'b1111, 1'b0, 8'h5A);
    applyStimulus(1'b0, 4'b0000, 8'h00, 4'b0100, 1'b0); checkCycle("mc2", 4'b1011, 1'b0, 8'h5A);
    applyStimulus(1'b0, 4'b0000, 8'h00, 4'b0111, 1'b0); checkCycle("mc3", 4'b1011, 1'b0, 8'h5A);
    applyStimulus(1'b0, 4'b0000, 8'h00, 4'b0111, 1'b0); checkCycle("mc4", 4'b1000, 1'b0, 8'h5A);
    applyStimulus(1'b1, 4'b0100, 8'h11, 4'b1111, 1'b1); checkCycle("mc5", 4'b1000, 1'b1, 8'h5A);
    applyStimulus(1'b0, 4'b0000, 8'h00, 4'b1111, 1'b0); checkCycle("b2b", 4'b0100, 1'b1, 8'h11);
    applyStimulus(1'b0, 4'b0000, 8'h00, 4'b1111, 1'b0); checkCycle("b2b_idle", 4'b0000, 1'b1, 8'h00);

    // Zero-mask item is consumed without appearing; the next item goes to way 3.
    applyStimulus(1'b1, 4'b0000, 8'h33, 4'hF, 1'b0); checkCycle("zm0", 4'b0000, 1'b1, 8'h00);
    applyStimulus(1'b1, 4'b1000, 8'h44, 4'hF, 1'b1); checkCycle("zm1", 4'b0000, 1'b1, 8'h00);
`ifdef BASE_SCATTER_DROP_CNT_EN
    checkOutput("drop_cnt_one", 32'(drop_cnt4), 32'd1);
`endif
    applyStimulus(1'b0, 4'b0000, 8'h00, 4'hF, 1'b0); checkCycle("zm2", 4'b1000, 1'b1, 8'h44);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'b0000, 8'hE0 + 8'(i), 4'hF, 1'b0);
      checkCycle("zm_drop", 4'b0000, 1'b1, 8'h00);
    end
    applyStimulus(1'b0, 4'b0000, 8'h00, 4'hF, 1'b0); checkCycle("zm_idle", 4'b0000, 1'b1, 8'h00);
`ifdef BASE_SCATTER_DROP_CNT_EN
    checkOutput("drop_cnt_sat", 32'(drop_cnt4), 32'd3);
`endif

    // Reset between edges while ways 1 and 2 are pending.
    applyStimulus(1'b1, 4'b0110, 8'h77, 4'b0000, 1'b1); checkCycle("rm0", 4'b0000, 1'b1, 8'h00);
    applyStimulus(1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0); checkCycle("rm1", 4'b0110, 1'b0, 8'h77);
    exp4[1].delete();
    exp4[2].delete();
    #2 reset = 1'b0;
    #1;
    checkOutput("rm_async_o_v", 32'(bus4.o_v), 32'd0);
    checkOutput("rm_async_i_r", 32'(bus4.i_r), 32'd1);
    checkOutput("rm_async_o_k", 32'(bus4.o_k), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    applyStimulus(1'b1, 4'b0001, 8'h88, 4'hF, 1'b1); checkCycle("rm2", 4'b0000, 1'b1, 8'h00);
    applyStimulus(1'b0, 4'b0000, 8'h00, 4'hF, 1'b0); checkCycle("rm3", 4'b0001, 1'b1, 8'h88);
    applyStimulus(1'b0, 4'b0000, 8'h00, 4'hF, 1'b0); checkCycle("rm4", 4'b0000, 1'b1, 8'h00);

    // Single-way instance: ready toggles 1,0,1 under a continuous stream.
    applyStimulusOne(1'b1, 1'b1, 8'hB0, 1'b1, 1'b1); checkCycleOne("one0", 1'b0, 1'b1, 8'h00);
    applyStimulusOne(1'b1, 1'b1, 8'hB1, 1'b0, 1'b0); checkCycleOne("one1", 1'b1, 1'b0, 8'hB0);
    applyStimulusOne(1'b1, 1'b1, 8'hB1, 1'b1, 1'b1); checkCycleOne("one2", 1'b1, 1'b1, 8'hB0);
    applyStimulusOne(1'b1, 1'b0, 8'hCC, 1'b1, 1'b0); checkCycleOne("one3", 1'b1, 1'b1, 8'hB1);
    applyStimulusOne(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); checkCycleOne("one4", 1'b0, 1'b1, 8'h00);
`ifdef BASE_SCATTER_DROP_CNT_EN
    checkOutput("one_drop_cnt", 32'(drop_cnt1), 32'd1);
`endif
    applyStimulusOne(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); checkCycleOne("one5", 1'b0, 1'b1, 8'h00);

    for (int w = 0; w < 4; w++)
      checkOutput($sformatf("drained_w%0d", w), 32'(exp4[w].size()), 32'd0);
    checkOutput("drained_one", 32'(exp1.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
